spi_ram_responder: RTL
======================

Name: spi_ram_responder

Overview:
SPI mode-0 responder (slave) for the serial SRAM protocol that the SoC's SPI RAM master drives: READ (0x03) and WRITE (0x02), each followed by a 24-bit address and a byte stream.
- Backed by internal byte-wide RAM.
- Oversamples the SPI pins with the system clock, so it is fully synchronous to clk.
- Serves as the on-chip/FPGA stand-in for the external SPI SRAM and as the bench responder for the SPI RAM master.
- Includes a back-door port for preload and inspection.

Parameters:
ADDR_BITS, 10, log2 of RAM size in bytes (1 KiB default); low ADDR_BITS of the 24-bit address are used.
SYNC_STAGES, 2, synchronizer depth on spi_clk, spi_cs_n and spi_mosi (minimum 2).

Ports:
clk  in  1  system clock.
resetn  in  1  reset, asynchronous, active-low.
spi_clk  in  1  SPI clock from master, idle low (mode 0).
spi_cs_n  in  1  chip select, active low.
spi_mosi  in  1  master-out data, MSB first.
spi_miso  out  1  slave-out data, MSB first; driven 0 when not returning read data.
busy  out  1  high while synchronized spi_cs_n is low.
bd_addr  in  ADDR_BITS  back-door byte address.
bd_we  in  1  back-door write strobe.
bd_wdata  in  8  back-door write data.
bd_rdata  out  8  back-door read data, registered, 1-cycle latency.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, shift/bit counters 0, address 0, spi_miso=0, busy=0, bd_rdata=0, synchronizer flops at idle levels (clk 0, cs_n 1, mosi 0). RAM contents are not reset.
- Input path: spi_clk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops. Rise and fall of spi_clk are detected from the last two synchronized samples.
- MOSI sampling: on detected rise only. MISO update: on detected fall only. MSB first.
- Timing requirement: spi_clk period >= 8 clk periods (each half-period >= 4 clk). Faster spi_clk is unsupported.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE.
  - IDLE -> CMD on synchronized cs_n falling.
  - CMD: shift 8 bits. On the 8th rise: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
  - ADDR: shift 24 bits. On the 24th rise, latch address[ADDR_BITS-1:0] (upper bits discarded) and go to RD_DATA or WR_DATA.
  - RD_DATA:
    - The RAM read is issued in the cycle after the 24th address rise, and the byte is loaded into the tx shifter.
    - Bit 7 appears on spi_miso at the next detected fall; bits 6..0 follow on subsequent falls.
    - After a byte's 8th fall, the next byte (address+1) is already loaded and its bit 7 is driven on the following fall. The next byte's read is issued on that byte's 4th rise.
  - WR_DATA: on every 8th rise, write the shifted byte to RAM[address] in the next clk, then address+1.
  - IGNORE: spi_miso=0, no RAM access.
- Any state -> IDLE on synchronized cs_n high (takes priority over a simultaneous edge):
  - A partial data byte (<8 bits) is discarded; RAM is unchanged.
  - A partial command or address is discarded.
  - spi_miso returns to 0 in the same cycle.
- Address increment wraps modulo 2^ADDR_BITS: last byte -> byte 0, for both reads and writes.
- spi_miso is held 0 in IDLE, CMD, ADDR, WR_DATA and IGNORE.
- Back-door access:
  - Reads are always allowed, including while busy.
  - bd_we is honoured only when busy=0; it is ignored while busy.
  - When an SPI write and a back-door read hit the same address in the same cycle, bd_rdata returns the old data (read-first).
- busy tracks synchronized cs_n with SYNC_STAGES latency.

Decomposition:
- Package spi_ram_pkg:
  - opcode constants OP_READ=8'h03, OP_WRITE=8'h02;
  - FSM state encoding;
  - ADDR_FIELD_BITS=24.
- One sub-module, spi_ram_sync_edge: SYNC_STAGES synchronizer for the three pins plus spi_clk rise/fall pulse outputs.
- RAM is inferred inside spi_ram_responder as a single-port-per-side array (SPI side plus back-door side).

Test Plan:
- Write: cs low; send 02 00 00 10 A5 3C; cs high -> bd read 0x010 = A5, 0x011 = 3C; all other bytes unchanged.
- Read: back-door preload 0x020..0x023 = 11 22 33 44; send 03 00 00 20 then 32 dummy clocks -> MISO returns 11 22 33 44 MSB first, sampled on master rises.
- Wrap and truncation: write 02 01 23 FF AA BB -> RAM[0x3FF]=AA, RAM[0x000]=BB (upper address bits ignored with ADDR_BITS=10).
- Unknown opcode: send 9F 00 00 00 FF FF -> spi_miso stays 0 throughout; full RAM compare unchanged; busy follows cs.
- Abort mid-byte: 02 00 00 40, then 4 data bits, then cs high -> RAM[0x040] unchanged; the next transaction (read of 0x040) decodes correctly.
- Reset mid-read: assert resetn low during RD_DATA -> spi_miso=0 and busy=0 immediately; after release, a fresh 03 00 00 20 read returns the preloaded data.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM responder: opcodes, address field
// width and the protocol state encoding.
package spi_ram_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int ADDR_FIELD_BITS = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_sync_edge.sv
// Brings the three SPI pins into the clk domain and turns spi_clk into
// single-cycle rise/fall pulses. SYNC_STAGES must be at least 2.
module spi_ram_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   clk_prev;

    // Synchronizer chains; reset values match an idle bus (clock low, deselected).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_pipe  <= '0;
            cs_pipe   <= '1;
            mosi_pipe <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], spi_clk};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            clk_prev  <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = clk_pipe[SYNC_STAGES-1] & ~clk_prev;
    assign sclk_fall = ~clk_pipe[SYNC_STAGES-1] & clk_prev;
    assign cs_n_sync = cs_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial SRAM responder (READ 0x03 / WRITE 0x02 + 24-bit
// address + byte stream) backed by an internal byte RAM, oversampled by
// clk, with a back-door port for preload and inspection.
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 spi_clk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 busy,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic                 bd_we,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
);

    localparam int RAM_DEPTH = 1 << ADDR_BITS;
    // Only the trailing bits of the address field survive truncation, so the
    // shifter keeps just enough history for the address or a full byte.
    localparam int SHIFT_W   = (ADDR_BITS > 8) ? ADDR_BITS - 1 : 7;

    logic [7:0]           ram [RAM_DEPTH];

    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 cs_n_sync;
    logic                 mosi_sync;

    state_t               state;
    state_t               next_state;

    logic [SHIFT_W-1:0]   shift_reg;
    logic [7:0]           rx_byte;
    logic [4:0]           bit_cnt;
    logic                 is_read;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-1:0] addr_next;
    logic [7:0]           tx_shift;
    logic [7:0]           next_byte;
    logic                 miso_bit;
    logic [2:0]           fall_cnt;
    logic [2:0]           rise_cnt;
    logic                 load_pending;
    logic                 wr_pending;
    logic [7:0]           wr_data;

    spi_ram_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_n_sync(cs_n_sync),
        .mosi_sync(mosi_sync)
    );

    assign rx_byte   = {shift_reg[6:0], mosi_sync};
    assign addr_next = addr + ADDR_BITS'(1);

    // Protocol state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; deselect overrides any clock edge in the same cycle.
    always_comb begin
        next_state = state;
        if (cs_n_sync) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: next_state = CMD;
                CMD: begin
                    if (sclk_rise && bit_cnt == 5'd7) begin
                        if (rx_byte == OP_READ || rx_byte == OP_WRITE) begin
                            next_state = ADDR;
                        end else begin
                            next_state = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise && bit_cnt == 5'(ADDR_FIELD_BITS - 1)) begin
                        next_state = is_read ? RD_DATA : WR_DATA;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Pin outputs; MISO is gated by deselect so it drops without waiting for IDLE.
    always_comb begin
        busy     = ~cs_n_sync;
        spi_miso = 1'b0;
        if (state == RD_DATA && !cs_n_sync) begin
            spi_miso = miso_bit;
        end
    end

    // Shifters, counters and address tracking for command, address and data phases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            is_read      <= 1'b0;
            addr         <= '0;
            tx_shift     <= '0;
            next_byte    <= '0;
            miso_bit     <= 1'b0;
            fall_cnt     <= '0;
            rise_cnt     <= '0;
            load_pending <= 1'b0;
            wr_pending   <= 1'b0;
            wr_data      <= '0;
        end else begin
            load_pending <= 1'b0;
            wr_pending   <= 1'b0;
            if (wr_pending) begin
                addr <= addr_next;
            end
            if (cs_n_sync) begin
                bit_cnt  <= '0;
                fall_cnt <= '0;
                rise_cnt <= '0;
                miso_bit <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_reg <= {shift_reg[SHIFT_W-2:0], mosi_sync};
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                is_read <= (rx_byte == OP_READ);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift_reg <= {shift_reg[SHIFT_W-2:0], mosi_sync};
                            if (bit_cnt == 5'(ADDR_FIELD_BITS - 1)) begin
                                bit_cnt      <= '0;
                                addr         <= {shift_reg[ADDR_BITS-2:0], mosi_sync};
                                load_pending <= is_read;
                                fall_cnt     <= '0;
                                rise_cnt     <= '0;
                                miso_bit     <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (load_pending) begin
                            tx_shift <= ram[addr];
                        end
                        if (sclk_fall) begin
                            miso_bit <= tx_shift[7];
                            fall_cnt <= fall_cnt + 3'd1;
                            if (fall_cnt == 3'd7) begin
                                tx_shift <= next_byte;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                        if (sclk_rise) begin
                            rise_cnt <= rise_cnt + 3'd1;
                            if (rise_cnt == 3'd3) begin
                                next_byte <= ram[addr_next];
                                addr      <= addr_next;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise) begin
                            shift_reg <= {shift_reg[SHIFT_W-2:0], mosi_sync};
                            if (bit_cnt == 5'd7) begin
                                bit_cnt    <= '0;
                                wr_pending <= 1'b1;
                                wr_data    <= rx_byte;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // RAM writes; a completed SPI byte wins, back-door writes only when deselected.
    always_ff @(posedge clk) begin
        if (wr_pending) begin
            ram[addr] <= wr_data;
        end else if (bd_we && !busy) begin
            ram[bd_addr] <= bd_wdata;
        end
    end

    // Back-door read port, registered and read-first against concurrent writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bd_rdata <= '0;
        end else begin
            bd_rdata <= ram[bd_addr];
        end
    end

endmodule
